// File: rtl/usb_line_editor.sv
// Line-buffered echo stage for the CDC-ACM console: collects a line with backspace
// editing and replays it on CR. Define USB_LINE_EDITOR_CRLF_EN to terminate lines with CR LF.
module usb_line_editor #(
  parameter int DEPTH = 64
) (
  input  logic       clock_48mhz,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       line_overflow,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    COLLECT,
    READ,
    SEND,
`ifdef USB_LINE_EDITOR_CRLF_EN
    TERM_LF,
`endif
    TERM_CR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          ovf_q, ovf_d;
  logic          wr_en, rd_en, accept;
  logic [7:0]    rd_data_q;
  logic [7:0]    mem [DEPTH];

  always_ff @(posedge clock_48mhz) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= COLLECT;
      count_q <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: the line buffer and its read register are deliberately not reset so they map onto block RAM.
  always_ff @(posedge clock_48mhz) begin
    if (wr_en) mem[count_q[AW-1:0]] <= in_data;
    if (rd_en) rd_data_q <= mem[rd_q];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    rd_d      = rd_q;
    ovf_d     = ovf_q;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    in_ready  = (state_q == COLLECT) && !reset;
    accept    = in_valid && in_ready;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          case (in_data)
            8'h0D: begin
              if (count_q == '0) begin
                state_d = TERM_CR;
              end else begin
                rd_d    = '0;
                state_d = READ;
              end
            end
            8'h0A: ;
            8'h08, 8'h7F: begin
              if (count_q != '0) count_d = count_q - CW'(1);
            end
            default: begin
              if (count_q < CW'(DEPTH)) begin
                wr_en   = 1'b1;
                count_d = count_q + CW'(1);
              end else begin
                ovf_d = 1'b1;
              end
            end
          endcase
        end
      end
      READ: begin
        rd_en   = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = rd_data_q;
        if (out_ready) begin
          if ({1'b0, rd_q} == count_q - CW'(1)) begin
            state_d = TERM_CR;
          end else begin
            rd_d    = rd_q + AW'(1);
            state_d = READ;
          end
        end
      end
      TERM_CR: begin
        out_valid = 1'b1;
        out_data  = 8'h0D;
        if (out_ready) begin
`ifdef USB_LINE_EDITOR_CRLF_EN
          state_d = TERM_LF;
`else
          state_d = COLLECT;
          count_d = '0;
          rd_d    = '0;
          ovf_d   = 1'b0;
`endif
        end
      end
`ifdef USB_LINE_EDITOR_CRLF_EN
      TERM_LF: begin
        out_valid = 1'b1;
        out_data  = 8'h0A;
        if (out_ready) begin
          state_d = COLLECT;
          count_d = '0;
          rd_d    = '0;
          ovf_d   = 1'b0;
        end
      end
`endif
      default: state_d = COLLECT;
    endcase
  end

  assign line_overflow = ovf_q;
  assign busy          = (state_q != COLLECT);

endmodule

// File: tb/tb_usb_line_editor.sv
// Scoreboarded bench for usb_line_editor: a line-level reference model queues the expected
// echo bytes, and an independent monitor pops and compares them on every output handshake.
module tb_usb_line_editor;

  localparam int DEPTH = 4;
`ifdef USB_LINE_EDITOR_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic       clock_48mhz = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       line_overflow;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned exp_q[$];
  byte unsigned line_m[$];
  bit           ovf_m = 1'b0;
  bit           rand_ready = 1'b0;
  bit           have_hold = 1'b0;
  logic [7:0]   hold_data;

  usb_line_editor #(.DEPTH(DEPTH)) dut (
    .clock_48mhz  (clock_48mhz),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .line_overflow(line_overflow),
    .busy         (busy)
  );

  always #10 clock_48mhz = ~clock_48mhz;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clock_48mhz);
    #1;
  endtask

  // Reference model: an editable line; CR releases it plus terminator to the scoreboard.
  task automatic model_accept(input byte unsigned b);
    case (b)
      8'h0D: begin
        foreach (line_m[i]) exp_q.push_back(line_m[i]);
        exp_q.push_back(8'h0D);
        if (CRLF) exp_q.push_back(8'h0A);
        line_m.delete();
        ovf_m = 1'b0;
      end
      8'h0A: ;
      8'h08, 8'h7F: if (line_m.size() > 0) void'(line_m.pop_back());
      default: begin
        if (line_m.size() < DEPTH) line_m.push_back(b);
        else ovf_m = 1'b1;
      end
    endcase
  endtask

  task automatic send_byte(input byte unsigned b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clock_48mhz);
    while (!in_ready && n < 1000) begin
      @(negedge clock_48mhz);
      n++;
    end
    if (!in_ready) begin
      check("in_ready timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    check("line_overflow before accept", line_overflow, ovf_m);
    model_accept(b);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock_48mhz);
    while (!(exp_q.size() == 0 && in_ready && !out_valid) && n < 3000) begin
      @(negedge clock_48mhz);
      n++;
    end
    check("idle: pending expected bytes", exp_q.size(), 0);
    check("idle: in_ready", in_ready, 1);
    check("idle: line_overflow", line_overflow, 0);
    step();
  endtask

  task automatic wait_out_valid();
    int n = 0;
    @(negedge clock_48mhz);
    while (!out_valid && n < 100) begin
      @(negedge clock_48mhz);
      n++;
    end
    check("out_valid timeout", out_valid, 1);
  endtask

  // Monitor: compares every output handshake and holds stalled outputs to their first value.
  always @(negedge clock_48mhz) begin
    if (reset) begin
      have_hold = 1'b0;
    end else begin
      if (have_hold) begin
        check("stalled out_valid held", out_valid, 1);
        check("stalled out_data held", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        have_hold = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected output: got 0x%0h, expected no byte", out_data);
        end else begin
          check("output byte", out_data, exp_q.pop_front());
        end
      end else if (out_valid) begin
        have_hold = 1'b1;
        hold_data = out_data;
      end else begin
        have_hold = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock_48mhz);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit vseq[$];
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(posedge clock_48mhz);
    @(negedge clock_48mhz);
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset busy", busy, 0);
    check("reset line_overflow", line_overflow, 0);
    step();
    reset = 1'b0;
    @(negedge clock_48mhz);
    check("in_ready after reset", in_ready, 1);
    step();

    // "abc" CR with out_ready high: cycle-exact valid pattern after the CR.
    out_ready = 1'b1;
    send_str("abc");
    send_byte(8'h0D);
    vseq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    if (CRLF) vseq.push_back(1'b1);
    foreach (vseq[i]) begin
      @(negedge clock_48mhz);
      check($sformatf("abc out_valid cycle %0d", i), out_valid, vseq[i]);
    end
    @(negedge clock_48mhz);
    check("abc in_ready after terminator", in_ready, 1);
    wait_idle();

    // Backspace editing, including a delete on an empty buffer.
    send_str("ab");
    send_byte(8'h08);
    send_str("c");
    send_byte(8'h7F);
    send_byte(8'h7F);
    send_byte(8'h7F);
    send_str("x");
    send_byte(8'h0D);
    wait_idle();

    // Overflow at DEPTH=4.
    send_str("abcdef");
    @(negedge clock_48mhz);
    check("line_overflow after drop", line_overflow, 1);
    step();
    send_byte(8'h0D);
    wait_idle();

    // Empty line, then a discarded LF.
    send_byte(8'h0D);
    @(negedge clock_48mhz);
    check("empty line out_valid", out_valid, 1);
    check("empty line out_data", out_data, 8'h0D);
    check("empty line in_ready", in_ready, 0);
    check("empty line busy", busy, 1);
    step();
    send_byte(8'h0A);
    send_str("z");
    send_byte(8'h0D);
    wait_idle();

    // Stall during SEND of 'q'.
    out_ready = 1'b0;
    send_str("q");
    send_byte(8'h0D);
    repeat (22) @(negedge clock_48mhz);
    check("stall out_valid", out_valid, 1);
    check("stall out_data", out_data, 8'h71);
    step();
    out_ready = 1'b1;
    wait_idle();

    // Reset while the second character of the line is presented.
    out_ready = 1'b0;
    send_str("hello");
    send_byte(8'h0D);
    wait_out_valid();
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wait_out_valid();
    check("second char presented", out_data, 8'h65);
    step();
    reset = 1'b1;
    exp_q.delete();
    line_m.delete();
    ovf_m = 1'b0;
    step();
    check("mid-line reset out_valid", out_valid, 0);
    check("mid-line reset in_ready", in_ready, 0);
    reset = 1'b0;
    @(negedge clock_48mhz);
    check("in_ready after mid-line reset", in_ready, 1);
    check("out_valid after mid-line reset", out_valid, 0);
    step();
    out_ready = 1'b1;
    send_str("k");
    send_byte(8'h0D);
    wait_idle();

    // Randomized lines with random backpressure.
    rand_ready = 1'b1;
    for (int l = 0; l < 40; l++) begin
      int len;
      len = $urandom_range(0, 7);
      for (int c = 0; c < len; c++) begin
        int r;
        byte unsigned b;
        r = $urandom_range(0, 9);
        case (r)
          0: b = 8'h08;
          1: b = 8'h7F;
          2: b = 8'h0A;
          default: b = 8'h61 + 8'($urandom_range(0, 25));
        endcase
        send_byte(b);
      end
      send_byte(8'h0D);
    end
    wait_idle();
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
